// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: reads a burst of consecutive words from the read port
// of a dual-port RAM that has one cycle of read latency. The words are sent
// out as a valid/ready stream through a 2-entry output FIFO. A read is issued
// only when the FIFO has room for its data, so back-pressure from the sink
// never causes an overflow.
//
// Optional feature: define DPRAM_STREAM_READER_ABORT_EN to add the `abort`
// input. Asserting abort in RUN or DRAIN cancels the burst: the FIFO and any
// read in flight are dropped, and done is pulsed.
module dpram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef DPRAM_STREAM_READER_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;     // reads still to be issued
    logic                  inflight_q;      // a read was issued last cycle
    logic                  inflight_last_q; // that read is the final word
    logic [1:0]            count_q;         // FIFO occupancy, 0..2
    logic [DATA_WIDTH-1:0] e0_data, e1_data; // e0 is the head entry
    logic                  e0_last, e1_last;
    logic                  done_q;

    logic                  abort_hit;
    logic                  pop;
    logic                  start_ok;
    logic                  start_zero;
    logic [2:0]            level;
    logic                  issue;
    logic                  last_issue;

`ifdef DPRAM_STREAM_READER_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Handshake decode and read-issue decision.
    // level = words that will be held once this cycle's pop and the read in
    // flight land. A new read is allowed only while that stays below 2.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave a value held and infer a latch.
        pop        = 1'b0;
        start_ok   = 1'b0;
        start_zero = 1'b0;
        level      = 3'd0;
        issue      = 1'b0;
        last_issue = 1'b0;

        pop        = out_valid && out_ready;
        start_ok   = (state_q == IDLE) && start && (length != '0);
        start_zero = (state_q == IDLE) && start && (length == '0);
        level      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == RUN) && (remaining_q != '0) &&
                     (level < 3'd2) && !abort_hit;
        last_issue = issue && (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1});
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (abort_hit) state_d = IDLE;
                     else if (last_issue) state_d = DRAIN;
            DRAIN:   if (abort_hit) state_d = IDLE;
                     else if (pop && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Address/length counters, in-flight tracking, output FIFO and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q       <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            done_q          <= 1'b0;
            // NOTE: the two FIFO words are reset as well, so out_data reads 0 after reset.
            e0_data         <= '0;
            e1_data         <= '0;
            e0_last         <= 1'b0;
            e1_last         <= 1'b0;
        end else begin
            done_q <= start_zero || abort_hit || (pop && out_last);

            if (start_ok)   rd_addr_q <= start_addr;
            else if (issue) rd_addr_q <= rd_addr_q + 1'b1;

            if (start_ok)   remaining_q <= length;
            else if (issue) remaining_q <= remaining_q - 1'b1;

            if (abort_hit) begin
                inflight_q      <= 1'b0;
                inflight_last_q <= 1'b0;
                count_q         <= 2'd0;
            end else begin
                inflight_q      <= issue;
                inflight_last_q <= last_issue;
                // The push side is the read issued last cycle, whose data is now on rd_data.
                case ({inflight_q, pop})
                    2'b10: begin
                        if (count_q == 2'd0) begin
                            e0_data <= rd_data;
                            e0_last <= inflight_last_q;
                        end else begin
                            e1_data <= rd_data;
                            e1_last <= inflight_last_q;
                        end
                        count_q <= count_q + 2'd1;
                    end
                    2'b01: begin
                        e0_data <= e1_data;
                        e0_last <= e1_last;
                        count_q <= count_q - 2'd1;
                    end
                    2'b11: begin
                        if (count_q == 2'd1) begin
                            e0_data <= rd_data;
                            e0_last <= inflight_last_q;
                        end else begin
                            e0_data <= e1_data;
                            e0_last <= e1_last;
                            e1_data <= rd_data;
                            e1_last <= inflight_last_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = e0_data;
    assign out_last  = out_valid && e0_last;

endmodule
